reg_read_stage: RTL and testbench

In-order register-read/issue stage between decode and the execute pipes. Holds one decoded instruction, resolves each source operand from the forwarding unit or the register file under control of a register scoreboard, and issues to execute through a one-entry output register. Drives the source-register fields of the forwarding unit's register-read interface and consumes its hit/value results.

---
 rtl/reg_read_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_reg_read_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_stage
// Purpose  : In-order register-read/issue stage with scoreboard and optional
//            operand forwarding (enabled by defining RR_FWRD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module reg_read_stage #(
    parameter int NUM_FUS = 4,
    parameter int NREGS   = 32,
    parameter int XLEN    = 32,
    parameter int RW      = $clog2(NREGS),
    parameter int FSW     = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    in_src1_reg,
    input  logic [RW-1:0]    in_src2_reg,
    input  logic [RW-1:0]    in_dst_reg,
    input  logic             in_wen,
    input  logic [FSW-1:0]   in_fu_sel,
    output logic [RW-1:0]    rf_rd1_addr,
    output logic [RW-1:0]    rf_rd2_addr,
    input  logic [XLEN-1:0]  rf_rd1_data,
    input  logic [XLEN-1:0]  rf_rd2_data,
    output logic [RW-1:0]    fwrd_src1_reg,
    output logic [RW-1:0]    fwrd_src2_reg,
    input  logic             fwrd_src1_hit,
    input  logic             fwrd_src2_hit,
    input  logic [XLEN-1:0]  fwrd_src1_val,
    input  logic [XLEN-1:0]  fwrd_src2_val,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_dst_reg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_src1_val,
    output logic [XLEN-1:0]  out_src2_val,
    output logic [RW-1:0]    out_dst_reg,
    output logic             out_wen,
    output logic [FSW-1:0]   out_fu_sel
);

    logic             hold_valid_q, hold_valid_d;
    logic [RW-1:0]    src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic             wen_q, wen_d;
    logic [FSW-1:0]   fu_sel_q, fu_sel_d;
    logic             rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [XLEN-1:0]  val1_q, val1_d, val2_q, val2_d;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_src1_q, out_src1_d, out_src2_q, out_src2_d;
    logic [RW-1:0]    out_dst_q, out_dst_d;
    logic             out_wen_q, out_wen_d;
    logic [FSW-1:0]   out_fu_sel_q, out_fu_sel_d;

    logic [NREGS-1:0] busy_q, busy_d;

    logic             op1_rdy, op2_rdy;
    logic [XLEN-1:0]  op1_val, op2_val;
    logic             issue_fire;
    logic             accept;

    // Operand resolution: a latched operand is never re-resolved.
    always_comb begin
        op1_rdy = rdy1_q;
        op1_val = val1_q;
        if (!rdy1_q) begin
            if (src1_q == '0) begin
                op1_rdy = 1'b1;
                op1_val = '0;
            end
`ifdef RR_FWRD_EN
            else if (fwrd_src1_hit) begin
                op1_rdy = 1'b1;
                op1_val = fwrd_src1_val;
            end
`endif
            else if (!busy_q[src1_q]) begin
                op1_rdy = 1'b1;
                op1_val = rf_rd1_data;
            end
        end
    end

    always_comb begin
        op2_rdy = rdy2_q;
        op2_val = val2_q;
        if (!rdy2_q) begin
            if (src2_q == '0) begin
                op2_rdy = 1'b1;
                op2_val = '0;
            end
`ifdef RR_FWRD_EN
            else if (fwrd_src2_hit) begin
                op2_rdy = 1'b1;
                op2_val = fwrd_src2_val;
            end
`endif
            else if (!busy_q[src2_q]) begin
                op2_rdy = 1'b1;
                op2_val = rf_rd2_data;
            end
        end
    end

    // WAW check uses busy_q, i.e. the state before this cycle's write-back.
    assign issue_fire = hold_valid_q && op1_rdy && op2_rdy &&
                        !(wen_q && busy_q[dst_q]) &&
                        (!out_valid_q || out_ready);
    assign in_ready   = !hold_valid_q || issue_fire;
    assign accept     = in_valid && in_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        dst_d        = dst_q;
        wen_d        = wen_q;
        fu_sel_d     = fu_sel_q;
        rdy1_d       = rdy1_q;
        rdy2_d       = rdy2_q;
        val1_d       = val1_q;
        val2_d       = val2_q;
        out_valid_d  = out_valid_q;
        out_src1_d   = out_src1_q;
        out_src2_d   = out_src2_q;
        out_dst_d    = out_dst_q;
        out_wen_d    = out_wen_q;
        out_fu_sel_d = out_fu_sel_q;
        busy_d       = busy_q;

        if (hold_valid_q) begin
            rdy1_d = op1_rdy;
            val1_d = op1_val;
            rdy2_d = op2_rdy;
            val2_d = op2_val;
        end

        if (issue_fire) begin
            hold_valid_d = 1'b0;
            out_valid_d  = 1'b1;
            out_src1_d   = op1_val;
            out_src2_d   = op2_val;
            out_dst_d    = dst_q;
            out_wen_d    = wen_q;
            out_fu_sel_d = fu_sel_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            hold_valid_d = 1'b1;
            src1_d       = in_src1_reg;
            src2_d       = in_src2_reg;
            dst_d        = in_dst_reg;
            wen_d        = in_wen;
            fu_sel_d     = in_fu_sel;
            rdy1_d       = 1'b0;
            rdy2_d       = 1'b0;
            val1_d       = '0;
            val2_d       = '0;
        end

        // Clear first so a same-register set in the same cycle wins.
        if (wb_valid) begin
            busy_d[wb_dst_reg] = 1'b0;
        end
        if (issue_fire && wen_q) begin
            busy_d[dst_q] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (flush) begin
            hold_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            busy_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            wen_q        <= 1'b0;
            fu_sel_q     <= '0;
            rdy1_q       <= 1'b0;
            rdy2_q       <= 1'b0;
            val1_q       <= '0;
            val2_q       <= '0;
            out_valid_q  <= 1'b0;
            out_src1_q   <= '0;
            out_src2_q   <= '0;
            out_dst_q    <= '0;
            out_wen_q    <= 1'b0;
            out_fu_sel_q <= '0;
            busy_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            dst_q        <= dst_d;
            wen_q        <= wen_d;
            fu_sel_q     <= fu_sel_d;
            rdy1_q       <= rdy1_d;
            rdy2_q       <= rdy2_d;
            val1_q       <= val1_d;
            val2_q       <= val2_d;
            out_valid_q  <= out_valid_d;
            out_src1_q   <= out_src1_d;
            out_src2_q   <= out_src2_d;
            out_dst_q    <= out_dst_d;
            out_wen_q    <= out_wen_d;
            out_fu_sel_q <= out_fu_sel_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_rd1_addr = src1_q;
    assign rf_rd2_addr = src2_q;

`ifdef RR_FWRD_EN
    assign fwrd_src1_reg = src1_q;
    assign fwrd_src2_reg = src2_q;
`else
    assign fwrd_src1_reg = '0;
    assign fwrd_src2_reg = '0;
    logic unused_fwrd;
    assign unused_fwrd = ^{fwrd_src1_hit, fwrd_src2_hit, fwrd_src1_val, fwrd_src2_val};
`endif

    assign out_valid    = out_valid_q;
    assign out_src1_val = out_src1_q;
    assign out_src2_val = out_src2_q;
    assign out_dst_reg  = out_dst_q;
    assign out_wen      = out_wen_q;
    assign out_fu_sel   = out_fu_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_read_stage
// Purpose  : Directed self-checking bench for reg_read_stage (both RR_FWRD_EN
//            settings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_src1_reg, in_src2_reg, in_dst_reg;
    logic        in_wen;
    logic [1:0]  in_fu_sel;
    logic [4:0]  rf_rd1_addr, rf_rd2_addr;
    logic [31:0] rf_rd1_data, rf_rd2_data;
    logic [4:0]  fwrd_src1_reg, fwrd_src2_reg;
    logic        fwrd_src1_hit, fwrd_src2_hit;
    logic [31:0] fwrd_src1_val, fwrd_src2_val;
    logic        wb_valid;
    logic [4:0]  wb_dst_reg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1_val, out_src2_val;
    logic [4:0]  out_dst_reg;
    logic        out_wen;
    logic [1:0]  out_fu_sel;
    logic        rf_ones;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Register file contents: reg r holds 0xA50000rr unless forced to all ones.
    assign rf_rd1_data = rf_ones ? 32'hFFFF_FFFF : (32'hA500_0000 | {27'd0, rf_rd1_addr});
    assign rf_rd2_data = rf_ones ? 32'hFFFF_FFFF : (32'hA500_0000 | {27'd0, rf_rd2_addr});

    reg_read_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_src1_reg   (in_src1_reg),
        .in_src2_reg   (in_src2_reg),
        .in_dst_reg    (in_dst_reg),
        .in_wen        (in_wen),
        .in_fu_sel     (in_fu_sel),
        .rf_rd1_addr   (rf_rd1_addr),
        .rf_rd2_addr   (rf_rd2_addr),
        .rf_rd1_data   (rf_rd1_data),
        .rf_rd2_data   (rf_rd2_data),
        .fwrd_src1_reg (fwrd_src1_reg),
        .fwrd_src2_reg (fwrd_src2_reg),
        .fwrd_src1_hit (fwrd_src1_hit),
        .fwrd_src2_hit (fwrd_src2_hit),
        .fwrd_src1_val (fwrd_src1_val),
        .fwrd_src2_val (fwrd_src2_val),
        .wb_valid      (wb_valid),
        .wb_dst_reg    (wb_dst_reg),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_src1_val  (out_src1_val),
        .out_src2_val  (out_src2_val),
        .out_dst_reg   (out_dst_reg),
        .out_wen       (out_wen),
        .out_fu_sel    (out_fu_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic w, input logic [1:0] f);
        in_valid    = v;
        in_src1_reg = s1;
        in_src2_reg = s2;
        in_dst_reg  = d;
        in_wen      = w;
        in_fu_sel   = f;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; rf_ones = 1'b0;
        fwrd_src1_hit = 1'b0; fwrd_src2_hit = 1'b0;
        fwrd_src1_val = '0;   fwrd_src2_val = '0;
        wb_valid = 1'b0; wb_dst_reg = '0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);

        // Reset state
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_src1", out_src1_val, 32'd0);
        chk("rst_out_src2", out_src2_val, 32'd0);
        chk("rst_out_dst", {27'd0, out_dst_reg}, 32'd0);
        chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
        chk("rst_out_fu", {30'd0, out_fu_sel}, 32'd0);
        chk("rst_rf_addr1", {27'd0, rf_rd1_addr}, 32'd0);
        chk("rst_fwrd_src1", {27'd0, fwrd_src1_reg}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Two independent instructions back to back
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 2'd1);
        tick;
        drive(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 2'd2);
        #1;
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_rf_addr1", {27'd0, rf_rd1_addr}, 32'd1);
        chk("t1_rf_addr2", {27'd0, rf_rd2_addr}, 32'd2);
        chk("t1_out_valid_early", {31'd0, out_valid}, 32'd0);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t1_a_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_a_src1", out_src1_val, 32'hA500_0001);
        chk("t1_a_src2", out_src2_val, 32'hA500_0002);
        chk("t1_a_dst", {27'd0, out_dst_reg}, 32'd3);
        chk("t1_a_wen", {31'd0, out_wen}, 32'd1);
        chk("t1_a_fu", {30'd0, out_fu_sel}, 32'd1);
        tick;
        chk("t1_b_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_b_src1", out_src1_val, 32'hA500_0004);
        chk("t1_b_src2", out_src2_val, 32'hA500_0005);
        chk("t1_b_dst", {27'd0, out_dst_reg}, 32'd6);
        chk("t1_b_fu", {30'd0, out_fu_sel}, 32'd2);
        tick;
        chk("t1_drain", {31'd0, out_valid}, 32'd0);

        // RAW hazard on reg 7: forwarded or waits for write-back
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 2'd0);
        tick;
        drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b0, 2'd3);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t2_a_dst", {27'd0, out_dst_reg}, 32'd7);
        tick;
        chk("t2_b_stall", {31'd0, out_valid}, 32'd0);
        chk("t2_b_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef RR_FWRD_EN
        chk("t2_fwrd_src1", {27'd0, fwrd_src1_reg}, 32'd7);
`else
        chk("t2_fwrd_src1", {27'd0, fwrd_src1_reg}, 32'd0);
`endif
        fwrd_src1_hit = 1'b1;
        fwrd_src1_val = 32'hDEAD_BEEF;
        #1;
`ifdef RR_FWRD_EN
        chk("t2_fire_ready", {31'd0, in_ready}, 32'd1);
        tick;
        fwrd_src1_hit = 1'b0;
        chk("t2_fwd_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_fwd_src1", out_src1_val, 32'hDEAD_BEEF);
        chk("t2_fwd_src2", out_src2_val, 32'hA500_0002);
        chk("t2_fwd_dst", {27'd0, out_dst_reg}, 32'd8);
        chk("t2_fwd_fu", {30'd0, out_fu_sel}, 32'd3);
`else
        chk("t2_fire_ready", {31'd0, in_ready}, 32'd0);
        tick;
        fwrd_src1_hit = 1'b0;
        chk("t2_ignore_hit", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_dst_reg = 5'd7;
        tick;
        wb_valid = 1'b0;
        chk("t2_wb_cycle", {31'd0, out_valid}, 32'd0);
        tick;
        chk("t2_wb_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_wb_src1", out_src1_val, 32'hA500_0007);
        chk("t2_wb_dst", {27'd0, out_dst_reg}, 32'd8);
`endif
        tick;
        chk("t2_drain", {31'd0, out_valid}, 32'd0);

        // Register 0 always reads as zero
        rf_ones = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 2'd0);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        tick;
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_src1", out_src1_val, 32'd0);
        chk("t3_src2", out_src2_val, 32'd0);
        rf_ones = 1'b0;
        tick;

        // WAW on reg 9, busy bit survives same-target reissue
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 2'd3);
        tick;
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 2'd0);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t4_a_dst", {27'd0, out_dst_reg}, 32'd9);
        chk("t4_a_fu", {30'd0, out_fu_sel}, 32'd3);
        tick;
        chk("t4_b_stall", {31'd0, out_valid}, 32'd0);
        chk("t4_b_in_ready", {31'd0, in_ready}, 32'd0);
        wb_valid = 1'b1; wb_dst_reg = 5'd9;
        tick;
        wb_valid = 1'b0;
        chk("t4_b_wb_cycle", {31'd0, out_valid}, 32'd0);
        tick;
        chk("t4_b_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_b_dst", {27'd0, out_dst_reg}, 32'd9);
        chk("t4_b_fu", {30'd0, out_fu_sel}, 32'd0);
        drive(1'b1, 5'd9, 5'd0, 5'd11, 1'b0, 2'd0);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        tick;
        chk("t4_busy9_held", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_dst_reg = 5'd9;
        tick;
        wb_valid = 1'b0;
        tick;
        chk("t4_c_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_c_src1", out_src1_val, 32'hA500_0009);
        tick;

        // Output back-pressure
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd12, 1'b0, 2'd1);
        tick;
        drive(1'b1, 5'd4, 5'd5, 5'd13, 1'b0, 2'd2);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t5_d_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_d_dst", {27'd0, out_dst_reg}, 32'd12);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_dst", {27'd0, out_dst_reg}, 32'd12);
            chk("t5_hold_src1", out_src1_val, 32'hA500_0001);
            chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick;
        chk("t5_e_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_e_dst", {27'd0, out_dst_reg}, 32'd13);
        chk("t5_e_src2", out_src2_val, 32'hA500_0005);
        chk("t5_e_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        chk("t5_drain", {31'd0, out_valid}, 32'd0);

        // Flush with H and output valid, busy[3] and busy[6] set
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd14, 1'b0, 2'd0);
        tick;
        drive(1'b1, 5'd4, 5'd5, 5'd15, 1'b0, 2'd0);
        tick;
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 5'd1, 5'd2, 5'd20, 1'b0, 2'd0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick;
        chk("t6_accept_dropped", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 5'd3, 5'd6, 5'd16, 1'b0, 2'd0);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        tick;
        chk("t6_post_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_post_src1", out_src1_val, 32'hA500_0003);
        chk("t6_post_src2", out_src2_val, 32'hA500_0006);
        tick;

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd21, 1'b1, 2'd2);
        tick;
        drive(1'b1, 5'd4, 5'd5, 5'd22, 1'b0, 2'd1);
        tick;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        chk("t7_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t7_rst_dst", {27'd0, out_dst_reg}, 32'd0);
        chk("t7_rst_addr1", {27'd0, rf_rd1_addr}, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("t7_post_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
